// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB boundary.
// LSU opcode constants are also used by the memory stage's load/store decode.
package mem_wb_stage_pkg;

   localparam int unsigned DATA_W     = 32;
   localparam int unsigned ADDR_W     = 32;
   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned INST_W     = 32;

   localparam logic [3:0] LD_B  = 4'b0000;
   localparam logic [3:0] LD_H  = 4'b0001;
   localparam logic [3:0] LD_W  = 4'b0010;
   localparam logic [3:0] LD_BU = 4'b1000;
   localparam logic [3:0] LD_HU = 4'b1001;

   typedef struct packed {
      logic                  valid;
      logic [ADDR_W-1:0]     pc;
      logic [INST_W-1:0]     inst;
      logic                  rw_en;
      logic [REG_ADDR_W-1:0] rw_addr;
      logic [DATA_W-1:0]     rw_data;
      logic                  is_load;
      logic [3:0]            lsu_op;
   } mem_wb_t;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// load_align: selects the addressed byte/halfword of a word-aligned SRAM
// read and sign/zero-extends it.
// Ports:
//   ld_word    in  32  word-aligned load data
//   offset     in  2   byte offset within the word
//   op         in  4   LSU opcode
//   data       out 32  formatted load result (0 for unknown opcodes)
//   misaligned out 1   halfword at offset 3 or word at nonzero offset
module load_align
   import mem_wb_stage_pkg::*;
(
   input  logic [31:0] ld_word,
   input  logic [1:0]  offset,
   input  logic [3:0]  op,
   output logic [31:0] data,
   output logic        misaligned
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = 8'h00;
      case (offset)
         2'd0:    byte_sel = ld_word[7:0];
         2'd1:    byte_sel = ld_word[15:8];
         2'd2:    byte_sel = ld_word[23:16];
         default: byte_sel = ld_word[31:24];
      endcase

      // offset 3 is the misaligned case; its value is never committed
      half_sel = 16'h0000;
      case (offset)
         2'd0:    half_sel = ld_word[15:0];
         2'd1:    half_sel = ld_word[23:8];
         default: half_sel = ld_word[31:16];
      endcase

      data       = 32'h0000_0000;
      misaligned = 1'b0;
      case (op)
         LD_B:  data = {{24{byte_sel[7]}}, byte_sel};
         LD_BU: data = {24'h00_0000, byte_sel};
         LD_H: begin
            data       = {{16{half_sel[15]}}, half_sel};
            misaligned = (offset == 2'd3);
         end
         LD_HU: begin
            data       = {16'h0000, half_sel};
            misaligned = (offset == 2'd3);
         end
         LD_W: begin
            data       = ld_word;
            misaligned = (offset != 2'd0);
         end
         default: begin
            data       = 32'h0000_0000;
            misaligned = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM->WB pipeline register and load-result formatter.
// Captures the memory stage each cycle, consumes synchronous SRAM read data
// (valid one cycle after the request) and drives the register-file write
// port plus commit info. The SRAM word is buffered across stalls.
// Ports:
//   clock, reset (async, active-high)
//   stall, flush                 pipeline control
//   in_*                         memory-stage instruction fields
//   sram_rd_data                 word-aligned SRAM read data
//   wb_valid, wb_pc, wb_inst     commit info
//   rf_we, rf_waddr, rf_wdata    register-file write port / forwarding source
//   wb_ale                       misaligned-load flag
module mem_wb_stage
   import mem_wb_stage_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  in_valid,
   input  logic [ADDR_WIDTH-1:0] in_pc,
   input  logic [31:0]           in_inst,
   input  logic                  in_rw_en,
   input  logic [REG_ADDR_W-1:0] in_rw_addr,
   input  logic [DATA_WIDTH-1:0] in_rw_data,
   input  logic                  in_ram_rd_en,
   input  logic [3:0]            in_lsu_op,
   input  logic [DATA_WIDTH-1:0] sram_rd_data,
   output logic                  wb_valid,
   output logic [ADDR_WIDTH-1:0] wb_pc,
   output logic [31:0]           wb_inst,
   output logic                  rf_we,
   output logic [REG_ADDR_W-1:0] rf_waddr,
   output logic [DATA_WIDTH-1:0] rf_wdata,
   output logic                  wb_ale
);

   mem_wb_t               stage_d, stage_q;
   logic [DATA_WIDTH-1:0] hold_data_d, hold_data_q;
   logic                  hold_valid_d, hold_valid_q;

   logic [DATA_WIDTH-1:0] load_word;
   logic [DATA_WIDTH-1:0] load_data;
   logic                  load_misaligned;

   always_comb begin
      stage_d      = stage_q;
      hold_data_d  = hold_data_q;
      hold_valid_d = hold_valid_q;
      if (flush) begin
         stage_d.valid = 1'b0;
         hold_valid_d  = 1'b0;
      end else if (stall) begin
         // SRAM data is only valid the first cycle after capture; grab it
         // before it is overwritten by whatever the SRAM returns next.
         if (stage_q.valid && stage_q.is_load && !hold_valid_q) begin
            hold_data_d  = sram_rd_data;
            hold_valid_d = 1'b1;
         end
      end else begin
         stage_d.valid   = in_valid;
         stage_d.pc      = in_pc;
         stage_d.inst    = in_inst;
         stage_d.rw_en   = in_rw_en;
         stage_d.rw_addr = in_rw_addr;
         stage_d.rw_data = in_rw_data;
         stage_d.is_load = in_ram_rd_en;
         stage_d.lsu_op  = in_lsu_op;
         hold_valid_d    = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stage_q      <= '0;
         hold_data_q  <= '0;
         hold_valid_q <= 1'b0;
      end else begin
         stage_q      <= stage_d;
         hold_data_q  <= hold_data_d;
         hold_valid_q <= hold_valid_d;
      end
   end

   assign load_word = hold_valid_q ? hold_data_q : sram_rd_data;

   load_align u_load_align (
      .ld_word    (load_word),
      .offset     (stage_q.rw_data[1:0]),
      .op         (stage_q.lsu_op),
      .data       (load_data),
      .misaligned (load_misaligned)
   );

   assign wb_valid = stage_q.valid;
   assign wb_pc    = stage_q.pc;
   assign wb_inst  = stage_q.inst;
   assign wb_ale   = stage_q.valid & stage_q.is_load & load_misaligned;
   assign rf_we    = stage_q.valid & stage_q.rw_en & ~wb_ale;
   assign rf_waddr = stage_q.rw_addr;
   assign rf_wdata = stage_q.is_load ? load_data : stage_q.rw_data;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

   logic        clock;
   logic        reset;
   logic        stall;
   logic        flush;
   logic        in_valid;
   logic [31:0] in_pc;
   logic [31:0] in_inst;
   logic        in_rw_en;
   logic [4:0]  in_rw_addr;
   logic [31:0] in_rw_data;
   logic        in_ram_rd_en;
   logic [3:0]  in_lsu_op;
   logic [31:0] sram_rd_data;
   logic        wb_valid;
   logic [31:0] wb_pc;
   logic [31:0] wb_inst;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        wb_ale;

   int total = 0;
   int bad   = 0;

   mem_wb_stage dut (
      .clock        (clock),
      .reset        (reset),
      .stall        (stall),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_pc        (in_pc),
      .in_inst      (in_inst),
      .in_rw_en     (in_rw_en),
      .in_rw_addr   (in_rw_addr),
      .in_rw_data   (in_rw_data),
      .in_ram_rd_en (in_ram_rd_en),
      .in_lsu_op    (in_lsu_op),
      .sram_rd_data (sram_rd_data),
      .wb_valid     (wb_valid),
      .wb_pc        (wb_pc),
      .wb_inst      (wb_inst),
      .rf_we        (rf_we),
      .rf_waddr     (rf_waddr),
      .rf_wdata     (rf_wdata),
      .wb_ale       (wb_ale)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic en,
                        input logic [4:0] addr, input logic [31:0] data,
                        input logic ld, input logic [3:0] op);
      in_valid     = v;
      in_pc        = pc;
      in_inst      = pc ^ 32'hA5A5_0000;
      in_rw_en     = en;
      in_rw_addr   = addr;
      in_rw_data   = data;
      in_ram_rd_en = ld;
      in_lsu_op    = op;
   endtask

   task automatic cycle();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      stall = 1'b0;
      flush = 1'b0;
      sram_rd_data = 32'h0;
      drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 4'h0);
      #12;
      chk("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
      chk("rst_rf_we", {31'h0, rf_we}, 32'h0);
      chk("rst_rf_wdata", rf_wdata, 32'h0);
      chk("rst_wb_pc", wb_pc, 32'h0);
      chk("rst_wb_ale", {31'h0, wb_ale}, 32'h0);
      reset = 1'b0;

      // ALU pass-through
      drive(1'b1, 32'h100, 1'b1, 5'd5, 32'h1234_5678, 1'b0, 4'h0);
      cycle();
      chk("alu_we", {31'h0, rf_we}, 32'h1);
      chk("alu_waddr", {27'h0, rf_waddr}, 32'd5);
      chk("alu_wdata", rf_wdata, 32'h1234_5678);
      chk("alu_pc", wb_pc, 32'h100);
      chk("alu_inst", wb_inst, 32'hA5A5_0100);

      // load formatting
      sram_rd_data = 32'h80FF_7F01;
      drive(1'b1, 32'h104, 1'b1, 5'd6, 32'h1003, 1'b1, 4'b0000);
      cycle();
      chk("ldb_off3", rf_wdata, 32'hFFFF_FF80);
      chk("ldb_we", {31'h0, rf_we}, 32'h1);
      drive(1'b1, 32'h108, 1'b1, 5'd6, 32'h1003, 1'b1, 4'b1000);
      cycle();
      chk("ldbu_off3", rf_wdata, 32'h0000_0080);
      drive(1'b1, 32'h10C, 1'b1, 5'd6, 32'h1001, 1'b1, 4'b0000);
      cycle();
      chk("ldb_off1", rf_wdata, 32'h0000_007F);
      drive(1'b1, 32'h110, 1'b1, 5'd6, 32'h1001, 1'b1, 4'b0001);
      cycle();
      chk("ldh_off1", rf_wdata, 32'hFFFF_FF7F);
      drive(1'b1, 32'h114, 1'b1, 5'd6, 32'h1000, 1'b1, 4'b0001);
      cycle();
      chk("ldh_off0", rf_wdata, 32'h0000_7F01);
      drive(1'b1, 32'h118, 1'b1, 5'd6, 32'h1002, 1'b1, 4'b1001);
      cycle();
      chk("ldhu_off2", rf_wdata, 32'h0000_80FF);
      drive(1'b1, 32'h11C, 1'b1, 5'd6, 32'h1000, 1'b1, 4'b0010);
      cycle();
      chk("ldw_off0", rf_wdata, 32'h80FF_7F01);
      chk("ldw_ale", {31'h0, wb_ale}, 32'h0);

      // misaligned loads
      drive(1'b1, 32'h120, 1'b1, 5'd6, 32'h1002, 1'b1, 4'b0010);
      cycle();
      chk("ldw_off2_ale", {31'h0, wb_ale}, 32'h1);
      chk("ldw_off2_we", {31'h0, rf_we}, 32'h0);
      drive(1'b1, 32'h124, 1'b1, 5'd6, 32'h1003, 1'b1, 4'b0001);
      cycle();
      chk("ldh_off3_ale", {31'h0, wb_ale}, 32'h1);
      chk("ldh_off3_we", {31'h0, rf_we}, 32'h0);

      // unknown opcode on a load
      drive(1'b1, 32'h128, 1'b1, 5'd6, 32'h1000, 1'b1, 4'b0101);
      cycle();
      chk("unk_wdata", rf_wdata, 32'h0);
      chk("unk_ale", {31'h0, wb_ale}, 32'h0);

      // write to r0 passes through
      drive(1'b1, 32'h12C, 1'b1, 5'd0, 32'h0000_0042, 1'b0, 4'h0);
      cycle();
      chk("r0_we", {31'h0, rf_we}, 32'h1);
      chk("r0_waddr", {27'h0, rf_waddr}, 32'd0);

      // invalid instruction captured
      drive(1'b0, 32'h130, 1'b1, 5'd3, 32'h55, 1'b0, 4'h0);
      cycle();
      chk("inv_valid", {31'h0, wb_valid}, 32'h0);
      chk("inv_we", {31'h0, rf_we}, 32'h0);

      // stall after load: SRAM word must be held
      drive(1'b1, 32'h200, 1'b1, 5'd7, 32'h2000, 1'b1, 4'b0010);
      cycle();
      stall = 1'b1;
      drive(1'b1, 32'h204, 1'b1, 5'd9, 32'h0000_9999, 1'b0, 4'h0);
      #1;
      chk("stall_c0_wdata", rf_wdata, 32'h80FF_7F01);
      cycle();
      sram_rd_data = 32'hDEAD_BEEF;
      #1;
      chk("stall_c1_wdata", rf_wdata, 32'h80FF_7F01);
      chk("stall_c1_waddr", {27'h0, rf_waddr}, 32'd7);
      cycle();
      chk("stall_c2_wdata", rf_wdata, 32'h80FF_7F01);
      chk("stall_c2_pc", wb_pc, 32'h200);
      cycle();
      stall = 1'b0;
      #1;
      chk("release_wdata", rf_wdata, 32'h80FF_7F01);
      chk("release_we", {31'h0, rf_we}, 32'h1);
      cycle();
      chk("next_waddr", {27'h0, rf_waddr}, 32'd9);
      chk("next_wdata", rf_wdata, 32'h0000_9999);

      // flush and stall together: flush wins
      sram_rd_data = 32'h1111_2222;
      drive(1'b1, 32'h300, 1'b1, 5'd4, 32'h3000, 1'b1, 4'b0010);
      cycle();
      stall = 1'b1;
      cycle();
      chk("pre_flush_hold", {31'h0, dut.hold_valid_q}, 32'h1);
      flush = 1'b1;
      cycle();
      chk("flush_valid", {31'h0, wb_valid}, 32'h0);
      chk("flush_we", {31'h0, rf_we}, 32'h0);
      chk("flush_hold", {31'h0, dut.hold_valid_q}, 32'h0);
      flush = 1'b0;
      stall = 1'b0;

      // flush without stall
      drive(1'b1, 32'h304, 1'b1, 5'd4, 32'h77, 1'b0, 4'h0);
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      chk("flush_only_valid", {31'h0, wb_valid}, 32'h0);

      // async reset mid-stall with a valid load in WB
      drive(1'b1, 32'h400, 1'b1, 5'd8, 32'h4000, 1'b1, 4'b0010);
      cycle();
      stall = 1'b1;
      cycle();
      chk("pre_rst_valid", {31'h0, wb_valid}, 32'h1);
      chk("pre_rst_we", {31'h0, rf_we}, 32'h1);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_valid", {31'h0, wb_valid}, 32'h0);
      chk("arst_we", {31'h0, rf_we}, 32'h0);
      chk("arst_hold", {31'h0, dut.hold_valid_q}, 32'h0);
      chk("arst_pc", wb_pc, 32'h0);
      #5;
      reset = 1'b0;
      stall = 1'b0;
      cycle();
      chk("post_rst_wdata", rf_wdata, 32'h1111_2222);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
